ahb_lite_axi_lite_bridge_p: RTL and testbench
=============================================

Name: ahb_lite_axi_lite_bridge_p

Overview:
- Parametrised AHB-Lite slave to AXI4-Lite master bridge; one outstanding transfer at a time.
- Sits between the core's AHB-Lite bus and the AXI4-Lite peripheral/DDR-control interconnect.
- Generalised in address and data width.
- Adds: byte-lane strobe generation, independent AW/W handshakes, registered read data, and AXI error responses mapped to the AHB two-cycle ERROR response.

Parameters:
- ADDR_W, 32, address width of haddr/awaddr/araddr.
- DATA_W, 32, data bus width; legal values 32 or 64. STRB_W=DATA_W/8 and LANE_BITS=log2(STRB_W) are derived.
- CHECK_ALIGN, 1, when 1, a misaligned or oversize transfer gets an AHB ERROR with no AXI access.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- hsel  in  1  slave select.
- haddr  in  ADDR_W  AHB address.
- htrans  in  2  transfer type; only NONSEQ/SEQ (htrans[1]=1) start a transfer.
- hwrite  in  1  1=write.
- hsize  in  3  transfer size, 2^hsize bytes.
- hprot  in  4  protection.
- hwdata  in  DATA_W  write data, valid in the data phase.
- hready  in  1  bus-level ready.
- hreadyout  out  1  slave ready.
- hresp  out  1  1=ERROR.
- hrdata  out  DATA_W  read data.
- awaddr  out  ADDR_W, awprot out 3, awvalid out 1, awready in 1  write address channel.
- wdata  out  DATA_W, wstrb out STRB_W, wvalid out 1, wready in 1  write data channel.
- bresp  in  2, bvalid in 1, bready out 1  write response channel.
- araddr  out  ADDR_W, arprot out 3, arvalid out 1, arready in 1  read address channel.
- rdata  in  DATA_W, rresp in 2, rvalid in 1, rready out 1  read data channel.

Behaviour:
- Reset values: state=IDLE, hreadyout=1, hresp=0, hrdata=0, all valid/ready outputs 0, addr/data/strb/prot registers 0.
- Reset mid-transfer aborts the transfer unconditionally.
- Address-phase acceptance:
  - A transfer is accepted when hsel & htrans[1] & hready in state IDLE or ERR2.
  - On acceptance, register haddr, hwrite, hsize and prot.
  - IDLE/BUSY or unselected cycles: no state change; OKAY zero-wait.
- prot mapping: prot[0]=hprot[1], prot[1]=1, prot[2]=~hprot[0].
- Error check (CHECK_ALIGN=1): the transfer is an error when 2^hsize>STRB_W, or when haddr[hsize-1:0]≠0. Next state is ERR1, with no AXI activity.
- wstrb: ((1<<2^hsize)-1) << haddr[LANE_BITS-1:0], computed at acceptance.
- States and transitions:
  - IDLE: hreadyout=1, hresp=0.
  - WDATA: hreadyout=0. Captures hwdata into wdata; sets awvalid=1 and wvalid=1 → W_REQ.
  - W_REQ: awvalid drops on the cycle after awvalid&awready; wvalid drops on the cycle after wvalid&wready. The two handshakes are independent, in either order or simultaneous. When both are done → W_RESP with bready=1.
  - W_RESP: on bvalid, bready drops. bresp=OKAY(00) → IDLE; bresp≠00 → ERR1.
  - R_REQ: entered from acceptance with arvalid=1. On arready, arvalid drops, rready=1 → R_RESP.
  - R_RESP: on rvalid, hrdata<=rdata (captured even on error) and rready drops. rresp=00 → IDLE; else → ERR1.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1 → IDLE, or accepts a new transfer.
- awaddr/araddr/awprot/arprot hold stable while the corresponding valid is high.
- hreadyout is 0 in every state except IDLE and ERR2.
- Minimum latency with AXI ready/valid asserted immediately: write = 3 data-phase wait states, read = 2.
- AXI stall: the bridge waits indefinitely with valids held; no timeout.
- hrdata holds its last value outside read completions.

Test Plan:
- DATA_W=32 write: haddr=0x100, hsize=2, hwdata=0xDEADBEEF, AXI ready immediately → awaddr=0x100, wdata=0xDEADBEEF, wstrb=4'hF, hreadyout low for exactly 3 cycles, hresp=0.
- Byte write: haddr=0x103, hsize=0, DATA_W=64 → wstrb=8'h08. awready delayed 4 cycles while wready is immediate → wvalid drops first, awvalid holds, bready asserts only after both handshakes.
- Read: haddr=0x40, rdata=0x12345678 returned 5 cycles after arready → hrdata=0x12345678 when hreadyout rises, rready high exactly 1 handshake.
- Read with rresp=2'b10 → hrdata updated, then hresp=1 with hreadyout=0 for one cycle, then hresp=1 with hreadyout=1; a back-to-back transfer presented in ERR2 is accepted.
- Misaligned: haddr=0x102, hsize=2 → no awvalid/arvalid ever, two-cycle ERROR. Oversize: hsize=3 with DATA_W=32 → same.
- Assert reset while in W_REQ with awvalid=1 → next cycle all valids 0, hreadyout=1, state IDLE; a following read completes normally.

Source files
------------

// File: rtl/ahb_lite_axi_lite_bridge_p.sv
// rtl/ahb_lite_axi_lite_bridge_p.sv - AHB-Lite slave to AXI4-Lite master bridge, one transfer in flight
//
// Purpose: accepts AHB-Lite transfers and replays each one as a single AXI4-Lite
// read or write, stalling the AHB data phase until the AXI response returns.
// AXI error responses, misaligned transfers and oversize transfers all come back
// as the AHB two-cycle ERROR response.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   hsel..hready                AHB-Lite slave inputs (address phase + hwdata)
//   hreadyout, hresp, hrdata    AHB-Lite slave outputs
//   aw*/w*/b*                   AXI4-Lite write address, write data, write response
//   ar*/r*                      AXI4-Lite read address, read data
module ahb_lite_axi_lite_bridge_p #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int CHECK_ALIGN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hsel,
  input  logic [ADDR_W-1:0]   haddr,
  input  logic [1:0]          htrans,
  input  logic                hwrite,
  input  logic [2:0]          hsize,
  input  logic [3:0]          hprot,
  input  logic [DATA_W-1:0]   hwdata,
  input  logic                hready,
  output logic                hreadyout,
  output logic                hresp,
  output logic [DATA_W-1:0]   hrdata,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int LANE_BITS = $clog2(STRB_W);

  typedef enum logic [2:0] {
    IDLE, WDATA, W_REQ, W_RESP, R_REQ, R_RESP, ERR1, ERR2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          prot_q;

  logic                accept;
  logic                xfer_err;
  logic [STRB_W-1:0]   strb_next;
  int                  nbytes;
  int                  lane;

  logic unused_inputs;
  assign unused_inputs = ^{hprot[3:2], htrans[0]};

  // Both address channels share one register; it only changes on acceptance,
  // so it is stable for as long as either valid is high.
  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign awprot = prot_q;
  assign arprot = prot_q;

  always_comb begin
    accept   = hsel && htrans[1] && hready && (state == IDLE || state == ERR2);
    nbytes   = 1 << hsize;
    lane     = int'(haddr[LANE_BITS-1:0]);
    xfer_err = (CHECK_ALIGN != 0) &&
               ((nbytes > STRB_W) || ((haddr[6:0] & 7'(nbytes - 1)) != 7'd0));
    strb_next = '0;
    for (int i = 0; i < STRB_W; i++) begin
      strb_next[i] = (i >= lane) && (i < lane + nbytes);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      addr_q    <= '0;
      prot_q    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
    end else begin
      case (state)
        IDLE, ERR2: begin
          if (accept) begin
            addr_q <= haddr;
            prot_q <= {~hprot[0], 1'b1, hprot[1]};
            wstrb  <= strb_next;
            hreadyout <= 1'b0;
            if (xfer_err) begin
              state <= ERR1;
              hresp <= 1'b1;
            end else if (hwrite) begin
              state <= WDATA;
              hresp <= 1'b0;
            end else begin
              state   <= R_REQ;
              hresp   <= 1'b0;
              arvalid <= 1'b1;
            end
          end else begin
            state     <= IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
          end
        end
        WDATA: begin
          // hwdata is only valid in the data phase, one cycle after acceptance.
          wdata   <= hwdata;
          awvalid <= 1'b1;
          wvalid  <= 1'b1;
          state   <= W_REQ;
        end
        W_REQ: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          // A channel is finished if it handshakes now or already has.
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp == 2'b00) begin
              state     <= IDLE;
              hreadyout <= 1'b1;
            end else begin
              state <= ERR1;
              hresp <= 1'b1;
            end
          end
        end
        R_REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R_RESP;
          end
        end
        R_RESP: begin
          if (rvalid) begin
            hrdata <= rdata;
            rready <= 1'b0;
            if (rresp == 2'b00) begin
              state     <= IDLE;
              hreadyout <= 1'b1;
            end else begin
              state <= ERR1;
              hresp <= 1'b1;
            end
          end
        end
        ERR1: begin
          state     <= ERR2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_axi_lite_bridge_p.sv
// tb/tb_ahb_lite_axi_lite_bridge_p.sv - self-checking bench for ahb_lite_axi_lite_bridge_p
module tb_ahb_lite_axi_lite_bridge_p;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // shared AHB address-phase signals
  logic        hsel = 1'b0, hsel_w = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0, hready = 1'b1;
  logic [2:0]  hsize = '0;
  logic [3:0]  hprot = '0;

  // 32-bit instance
  logic [31:0] hwdata = '0, hrdata, awaddr, araddr, wdata, rdata = '0;
  logic        hreadyout, hresp, awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;

  // 64-bit instance
  logic [63:0] hwdata_w = '0, hrdata_w, wdata_w, rdata_w = '0;
  logic [31:0] awaddr_w, araddr_w;
  logic        hreadyout_w, hresp_w, awvalid_w, wvalid_w, bready_w, arvalid_w, rready_w;
  logic        awready_w = 0, wready_w = 0, bvalid_w = 0, arready_w = 0, rvalid_w = 0;
  logic [2:0]  awprot_w, arprot_w;
  logic [7:0]  wstrb_w;
  logic [1:0]  bresp_w = '0, rresp_w = '0;

  ahb_lite_axi_lite_bridge_p #(.ADDR_W(32), .DATA_W(32), .CHECK_ALIGN(1)) u32 (
    .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout),
    .hresp(hresp), .hrdata(hrdata), .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .araddr(araddr), .arprot(arprot),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready));

  ahb_lite_axi_lite_bridge_p #(.ADDR_W(32), .DATA_W(64), .CHECK_ALIGN(1)) u64 (
    .clk(clk), .reset(reset), .hsel(hsel_w), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hprot(hprot), .hwdata(hwdata_w), .hready(hready), .hreadyout(hreadyout_w),
    .hresp(hresp_w), .hrdata(hrdata_w), .awaddr(awaddr_w), .awprot(awprot_w), .awvalid(awvalid_w),
    .awready(awready_w), .wdata(wdata_w), .wstrb(wstrb_w), .wvalid(wvalid_w), .wready(wready_w),
    .bresp(bresp_w), .bvalid(bvalid_w), .bready(bready_w), .araddr(araddr_w), .arprot(arprot_w),
    .arvalid(arvalid_w), .arready(arready_w), .rdata(rdata_w), .rresp(rresp_w), .rvalid(rvalid_w),
    .rready(rready_w));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // AXI slave model for the 32-bit instance: each ready/valid follows its
  // partner after a programmable number of cycles; handshakes are logged.
  int dly_a = 0, dly_w = 0, dly_b = 0;
  logic [1:0]  xresp = '0;
  logic [31:0] rdata_v = '0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int b_hs = 0, r_hs = 0;
  bit valid_seen = 0;
  logic [31:0] log_awaddr, log_wdata, log_araddr;
  logic [3:0]  log_wstrb;
  logic [2:0]  log_awprot, log_arprot;

  initial begin
    forever begin
      @(negedge clk);
      awready = awvalid && (aw_cnt >= dly_a);
      if (awvalid && awready) begin log_awaddr = awaddr; log_awprot = awprot; end
      aw_cnt = awvalid ? aw_cnt + 1 : 0;
      wready = wvalid && (w_cnt >= dly_w);
      if (wvalid && wready) begin log_wdata = wdata; log_wstrb = wstrb; end
      w_cnt = wvalid ? w_cnt + 1 : 0;
      bvalid = bready && (b_cnt >= dly_b);
      bresp  = xresp;
      if (bvalid) b_hs++;
      b_cnt = bready ? b_cnt + 1 : 0;
      arready = arvalid && (ar_cnt >= dly_a);
      if (arvalid && arready) begin log_araddr = araddr; log_arprot = arprot; end
      ar_cnt = arvalid ? ar_cnt + 1 : 0;
      rvalid = rready && (r_cnt >= dly_b);
      rdata  = rdata_v;
      rresp  = xresp;
      if (rvalid) r_hs++;
      r_cnt = rready ? r_cnt + 1 : 0;
      if (awvalid || wvalid || arvalid) valid_seen = 1;
    end
  end

  typedef struct {
    bit wr; logic [31:0] addr; logic [2:0] size; logic [3:0] prot;
    logic [31:0] wd; logic [31:0] rd; logic [1:0] xr; int da; int dw; int db;
    bit bad; int waits; logic [3:0] strb;
  } vec_t;

  logic [31:0] last_rd = '0;

  // Entered and left just after a falling edge; the completion cycle of one
  // call is the address phase of the next, so transfers run back to back.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [3:0] pr, input logic [31:0] wd,
                      output int waits, output bit fin_resp, output bit low_resp);
    hsel = 1; haddr = a; htrans = 2'b10; hwrite = wr; hsize = sz; hprot = pr;
    @(posedge clk); @(negedge clk);
    hsel = 0; htrans = 2'b00; hwdata = wd;
    waits = 0; low_resp = 0;
    while (!hreadyout && waits < 200) begin
      waits++; low_resp = hresp;
      @(negedge clk);
    end
    fin_resp = hresp;
  endtask

  task automatic run(input vec_t v);
    int w, bh, rh;
    bit fr, lr, exp_err;
    logic [2:0] pexp;
    dly_a = v.da; dly_w = v.dw; dly_b = v.db; xresp = v.xr; rdata_v = v.rd;
    bh = b_hs; rh = r_hs; valid_seen = 0;
    xfer(v.wr, v.addr, v.size, v.prot, v.wd, w, fr, lr);
    exp_err = v.bad || (v.xr != 2'b00);
    pexp = {~v.prot[0], 1'b1, v.prot[1]};
    chk("wait_states", 64'(w), 64'(v.waits));
    chk("hresp_final", 64'(fr), 64'(exp_err));
    chk("hresp_first_err_cycle", 64'(lr), 64'(exp_err));
    if (v.bad) begin
      chk("axi_valid_on_bad_xfer", 64'(valid_seen), 64'd0);
    end else if (v.wr) begin
      chk("awaddr", 64'(log_awaddr), 64'(v.addr));
      chk("wdata", 64'(log_wdata), 64'(v.wd));
      chk("wstrb", 64'(log_wstrb), 64'(v.strb));
      chk("awprot", 64'(log_awprot), 64'(pexp));
      chk("b_handshakes", 64'(b_hs - bh), 64'd1);
    end else begin
      chk("araddr", 64'(log_araddr), 64'(v.addr));
      chk("arprot", 64'(log_arprot), 64'(pexp));
      chk("r_handshakes", 64'(r_hs - rh), 64'd1);
      last_rd = v.rd;
    end
    chk("hrdata", 64'(hrdata), 64'(last_rd));
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    //             wr    addr      sz    prot   wd             rd             xr  da dw db  bad waits strb
    tbl[0]  = '{1'b1, 32'h100, 3'd2, 4'h0, 32'hDEADBEEF, 32'h0,        2'd0, 0, 0, 0, 1'b0, 3, 4'hF};
    tbl[1]  = '{1'b1, 32'h101, 3'd0, 4'h3, 32'h000000AA, 32'h0,        2'd0, 0, 0, 0, 1'b0, 3, 4'h2};
    tbl[2]  = '{1'b1, 32'h102, 3'd1, 4'h1, 32'hBEEF0000, 32'h0,        2'd0, 0, 0, 0, 1'b0, 3, 4'hC};
    tbl[3]  = '{1'b1, 32'h102, 3'd2, 4'h0, 32'h11111111, 32'h0,        2'd0, 0, 0, 0, 1'b1, 1, 4'h0};
    tbl[4]  = '{1'b1, 32'h100, 3'd3, 4'h0, 32'h22222222, 32'h0,        2'd0, 0, 0, 0, 1'b1, 1, 4'h0};
    tbl[5]  = '{1'b0, 32'h040, 3'd2, 4'h2, 32'h0,        32'h12345678, 2'd0, 0, 0, 5, 1'b0, 7, 4'h0};
    tbl[6]  = '{1'b0, 32'h044, 3'd2, 4'h0, 32'h0,        32'hCAFEF00D, 2'd2, 0, 0, 0, 1'b0, 3, 4'h0};
    tbl[7]  = '{1'b1, 32'h108, 3'd2, 4'h1, 32'h33333333, 32'h0,        2'd3, 0, 0, 0, 1'b0, 4, 4'hF};
    tbl[8]  = '{1'b1, 32'h10C, 3'd2, 4'h0, 32'h44444444, 32'h0,        2'd0, 2, 0, 1, 1'b0, 6, 4'hF};
    tbl[9]  = '{1'b1, 32'h110, 3'd2, 4'h2, 32'h55555555, 32'h0,        2'd0, 0, 3, 0, 1'b0, 6, 4'hF};
    tbl[10] = '{1'b0, 32'h043, 3'd1, 4'h0, 32'h0,        32'h66666666, 2'd0, 0, 0, 0, 1'b1, 1, 4'h0};
    tbl[11] = '{1'b0, 32'h049, 3'd0, 4'h0, 32'h0,        32'h00000055, 2'd0, 3, 0, 0, 1'b0, 5, 4'h0};

    repeat (3) @(negedge clk);
    reset = 0;
    chk("reset_hreadyout", 64'(hreadyout), 64'd1);
    chk("reset_hresp", 64'(hresp), 64'd0);
    chk("reset_hrdata", 64'(hrdata), 64'd0);
    chk("reset_handshake_outs", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("reset_regs", 64'({awaddr, wstrb, awprot}), 64'd0);

    for (int i = 0; i < 12; i++) run(tbl[i]);

    // 64-bit byte write: W handshakes at once, AW only after four cycles.
    hsel_w = 1; haddr = 32'h103; htrans = 2'b10; hwrite = 1; hsize = 3'd0; hprot = 4'h0;
    @(posedge clk); @(negedge clk);
    hsel_w = 0; htrans = 2'b00; hwdata_w = 64'h1122334455667788;
    @(posedge clk); @(negedge clk);
    chk("w64_wstrb", 64'(wstrb_w), 64'h08);
    chk("w64_wdata", wdata_w, 64'h1122334455667788);
    chk("w64_awaddr", 64'(awaddr_w), 64'h103);
    chk("w64_both_valid", 64'({awvalid_w, wvalid_w, bready_w}), 64'b110);
    wready_w = 1; @(posedge clk); @(negedge clk); wready_w = 0;
    for (int i = 0; i < 3; i++) begin
      chk("w64_aw_held_w_dropped", 64'({awvalid_w, wvalid_w, bready_w, hreadyout_w}), 64'b1000);
      @(posedge clk); @(negedge clk);
    end
    awready_w = 1; @(posedge clk); @(negedge clk); awready_w = 0;
    chk("w64_bready_after_both", 64'({awvalid_w, wvalid_w, bready_w}), 64'b001);
    bvalid_w = 1; bresp_w = 2'b00; @(posedge clk); @(negedge clk); bvalid_w = 0;
    chk("w64_done", 64'({hreadyout_w, hresp_w, bready_w}), 64'b100);

    // Reset while W_REQ is stalled with awvalid high.
    dly_a = 5; dly_w = 5;
    hsel = 1; haddr = 32'h200; htrans = 2'b10; hwrite = 1; hsize = 3'd2; hprot = 4'h0;
    @(posedge clk); @(negedge clk);
    hsel = 0; htrans = 2'b00; hwdata = 32'h1234;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_awvalid_before", 64'(awvalid), 64'd1);
    reset = 1;
    @(posedge clk); @(negedge clk);
    reset = 0;
    chk("rst_mid_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    chk("rst_mid_hready_hresp", 64'({hreadyout, hresp}), 64'b10);
    last_rd = '0;
    v = '{1'b0, 32'h050, 3'd2, 4'h0, 32'h0, 32'hA5A55A5A, 2'd0, 0, 0, 0, 1'b0, 2, 4'h0};
    run(v);

    // Randomised transfers against the rule-level model.
    for (int k = 0; k < 60; k++) begin
      int nb;
      v.wr   = 1'($urandom_range(0, 1));
      v.size = 3'($urandom_range(0, 3));
      v.addr = 32'h1000 + 32'($urandom_range(0, 15));
      v.prot = 4'($urandom_range(0, 15));
      v.wd   = $urandom;
      v.rd   = $urandom;
      v.xr   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      v.da   = $urandom_range(0, 3);
      v.dw   = $urandom_range(0, 3);
      v.db   = $urandom_range(0, 3);
      nb     = 1 << v.size;
      v.bad  = (nb > 4) || ((v.addr % nb) != 0);
      v.strb = 4'(((1 << nb) - 1) << (v.addr % 4));
      if (v.bad)
        v.waits = 1;
      else
        v.waits = (v.wr ? 3 + ((v.da > v.dw) ? v.da : v.dw) + v.db : 2 + v.da + v.db)
                  + ((v.xr != 2'd0) ? 1 : 0);
      run(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
